// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver. 5..9 data bits (LSB first),
//               none/odd/even parity, 1 or 2 stop bits, parity and framing
//               error flags. Defining UART_RX_FIFO_EN adds a receive FIFO
//               (rd_en / fifo_count / overrun ports); otherwise the last
//               word is held on the outputs with a one-cycle data_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_HZ     = 66_000_000,
    parameter int BAUD       = 9_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
`ifdef UART_RX_FIFO_EN
    input  logic                          rd_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                          overrun,
`endif
    output logic [DATA_BITS-1:0]          data,
    output logic                          data_valid,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int c_bit_clk  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_half_clk = c_bit_clk / 2;
    localparam int c_cnt_w    = ($clog2(c_bit_clk) < 1) ? 1 : $clog2(c_bit_clk);
    localparam int c_idx_w    = $clog2(DATA_BITS);

    localparam logic [c_cnt_w-1:0] c_bit_load  = c_cnt_w'(c_bit_clk - 1);
    localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(c_half_clk - 1);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_BITS - 1);
    localparam logic               c_last_stop = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_data    = 3'd2;
    localparam logic [2:0] c_st_parity  = 3'd3;
    localparam logic [2:0] c_st_stop    = 3'd4;
    localparam logic [2:0] c_st_recover = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic [2:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_idx_w-1:0]   w_idx_nxt;
    logic                 w_stop_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_perr_nxt;
    logic                 w_ferr_nxt;
    logic                 w_tick;
    logic                 w_emit;
    logic                 w_emit_pe;
    logic                 w_emit_fe;

    // Two-flop synchroniser for the asynchronous line, idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit timer, bit indices and frame accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_idx <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    assign w_tick = (r_cnt == '0);

    // Next-state and datapath decode; every sample is taken when the down-counter hits zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_stop_nxt  = r_stop_idx;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_emit      = 1'b0;
        w_emit_fe   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!r_rx_s) begin
                    w_state_nxt = c_st_start;
                    w_cnt_nxt   = c_half_load;
                    w_perr_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            c_st_start: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_rx_s) begin
                    // Start bit did not survive to its mid-point: treat as a glitch
                    w_state_nxt = c_st_idle;
                end else begin
                    w_state_nxt = c_st_data;
                    w_cnt_nxt   = c_bit_load;
                    w_idx_nxt   = '0;
                end
            end
            c_st_data: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_cnt_nxt   = c_bit_load;
                    w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = (PARITY != 0) ? c_st_parity : c_st_stop;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            c_st_parity: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Odd parity expects the XOR over data and parity bit to be 1
                    w_perr_nxt  = ((^r_shift) ^ r_rx_s) != (PARITY == 1);
                    w_cnt_nxt   = c_bit_load;
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = c_st_stop;
                end
            end
            c_st_stop: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_emit_fe  = r_ferr | ~r_rx_s;
                    w_ferr_nxt = w_emit_fe;
                    if (r_stop_idx == c_last_stop) begin
                        w_emit      = 1'b1;
                        w_state_nxt = w_emit_fe ? c_st_recover : c_st_idle;
                    end else begin
                        w_stop_nxt = 1'b1;
                        w_cnt_nxt  = c_bit_load;
                    end
                end
            end
            c_st_recover: begin
                // Line held low (break): no start detection until it returns high
                if (r_rx_s) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_emit_pe = (PARITY != 0) ? r_perr : 1'b0;
    assign busy      = (r_state != c_st_idle);

`ifdef UART_RX_FIFO_EN
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_fw = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS+1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_fw-1:0]  r_count;
    logic                 r_overrun;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic [DATA_BITS+1:0] w_head;

    assign w_full  = (r_count == c_cnt_fw'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en & ~w_empty;
    // A pop in the same cycle frees the slot the push is about to use
    assign w_push  = w_emit & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_emit_fe, w_emit_pe, r_shift};
        end
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_emit & w_full & ~w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign data       = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign parity_err = w_empty ? 1'b0 : w_head[DATA_BITS];
    assign frame_err  = w_empty ? 1'b0 : w_head[DATA_BITS+1];
    assign data_valid = ~w_empty;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
`else
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr_q;
    logic                 r_ferr_q;
    logic                 r_valid;

    // Hold the last emitted word and flags; data_valid marks the emit cycle only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_perr_q <= 1'b0;
            r_ferr_q <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_data   <= r_shift;
                r_perr_q <= w_emit_pe;
                r_ferr_q <= w_emit_fe;
            end
        end
    end

    assign data       = r_data;
    assign parity_err = r_perr_q;
    assign frame_err  = r_ferr_q;
    assign data_valid = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param. Instance A is 8N1,
//               instance B is 8E2. Expected words come from a frame-level
//               model of what was put on the line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_HZ   = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLK  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF_CLK = BIT_CLK / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic [7:0] data_a, data_b;
    logic       dv_a, pe_a, fe_a, busy_a;
    logic       dv_b, pe_b, fe_b, busy_b;
`ifdef UART_RX_FIFO_EN
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic [2:0] cnt_a, cnt_b;
    logic       ovr_a, ovr_b;
    int         ovr_cnt = 0;
`endif

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [9:0] obs_a[$];
    logic [9:0] obs_b[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a),
`ifdef UART_RX_FIFO_EN
        .rd_en(rd_en_a), .fifo_count(cnt_a), .overrun(ovr_a),
`endif
        .data(data_a), .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b),
`ifdef UART_RX_FIFO_EN
        .rd_en(rd_en_b), .fifo_count(cnt_b), .overrun(ovr_b),
`endif
        .data(data_b), .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b)
    );

`ifdef UART_RX_FIFO_EN
    // Count overrun pulses on instance A
    always @(negedge clk) begin
        if (ovr_a) ovr_cnt++;
    end
`else
    // Record every delivered word
    always @(negedge clk) begin
        if (dv_a) obs_a.push_back({fe_a, pe_a, data_a});
        if (dv_b) obs_b.push_back({fe_b, pe_b, data_b});
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {frame_err, parity_err, data} for a frame as sent on the line
    function automatic logic [9:0] model(input logic [7:0] d, input int par, input logic pbit,
                                         input int nstop, input logic [1:0] stops);
        int   ones;
        logic pe;
        logic fe;
        ones = $countones(d) + int'(pbit);
        if (par == 0)      pe = 1'b0;
        else if (par == 1) pe = (ones % 2 == 0);
        else               pe = (ones % 2 == 1);
        fe = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stops[i]) fe = 1'b1;
        return {fe, pe, d};
    endfunction

    task automatic drive(input int sel, input logic v, input int n);
        if (n > 0) begin
            @(negedge clk);
            if (sel == 0) rx_a = v; else rx_b = v;
            repeat (n - 1) @(negedge clk);
        end
    endtask

    task automatic frame(input int sel, input logic [7:0] d, input logic pbit,
                         input logic [1:0] stops, input int idle_bits);
        drive(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
        if (sel == 1) drive(sel, pbit, BIT_CLK);
        drive(sel, stops[0], BIT_CLK);
        if (sel == 1) drive(sel, stops[1], BIT_CLK);
        drive(sel, 1'b1, BIT_CLK * idle_bits);
        if (sel == 0) exp_a.push_back(model(d, 0, pbit, 1, stops));
        else          exp_b.push_back(model(d, 2, pbit, 2, stops));
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic check_queue(input int sel, input string tag);
        logic [9:0] e, o;
        int n_exp, n_obs;
        if (sel == 0) begin n_exp = exp_a.size(); n_obs = obs_a.size(); end
        else          begin n_exp = exp_b.size(); n_obs = obs_b.size(); end
        check({tag, "_count"}, 32'(n_obs), 32'(n_exp));
        for (int i = 0; i < n_exp && i < n_obs; i++) begin
            if (sel == 0) begin e = exp_a.pop_front(); o = obs_a.pop_front(); end
            else          begin e = exp_b.pop_front(); o = obs_b.pop_front(); end
            check(tag, 32'(o), 32'(e));
        end
        exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    endtask
`else
    task automatic pop_a;
        @(negedge clk); rd_en_a = 1'b1;
        @(negedge clk); rd_en_a = 1'b0;
    endtask
`endif

    initial begin
        logic [7:0] d;
        logic       pb;
        logic [1:0] st;

        repeat (3) @(negedge clk);
        check("rst_data_a", 32'(data_a), 32'h0);
        check("rst_flags_a", {28'h0, dv_a, pe_a, fe_a, busy_a}, 32'h0);
        check("rst_flags_b", {28'h0, dv_b, pe_b, fe_b, busy_b}, 32'h0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * BIT_CLK);

`ifndef UART_RX_FIFO_EN
        // Three clean 8N1 frames
        frame(0, 8'h05, 1'b0, 2'b11, 8);
        frame(0, 8'h08, 1'b0, 2'b11, 8);
        frame(0, 8'h11, 1'b0, 2'b11, 8);
        check_queue(0, "t1_8n1");
        check("t1_hold", {22'h0, fe_a, pe_a, data_a}, 32'h011);

        // Short low pulse is rejected as a glitch
        drive(0, 1'b0, HALF_CLK / 2 + 2);
        check("t2_busy_start", 32'(busy_a), 32'h1);
        drive(0, 1'b1, HALF_CLK + 3);
        check("t2_busy_idle", 32'(busy_a), 32'h0);
        drive(0, 1'b1, 2 * BIT_CLK);
        check_queue(0, "t2_glitch");

        // Even parity with correct and wrong parity bit, two stop bits
        frame(1, 8'hA5, 1'b1, 2'b11, 3);
        frame(1, 8'hA5, 1'b0, 2'b11, 3);
        check_queue(1, "t3_parity");

        // Stop bit low followed by a break, then a clean frame
        frame(0, 8'h3C, 1'b0, 2'b00, 0);
        drive(0, 1'b0, 2 * BIT_CLK);
        check("t4_busy_break", 32'(busy_a), 32'h1);
        check_queue(0, "t4_frame_err");
        drive(0, 1'b1, 3 * BIT_CLK);
        check("t4_busy_idle", 32'(busy_a), 32'h0);
        frame(0, 8'h5A, 1'b0, 2'b11, 3);
        check_queue(0, "t4_recover");

        // Reset during the fourth data bit aborts the frame
        d = 8'h77;
        drive(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) drive(0, d[i], BIT_CLK);
        drive(0, d[3], HALF_CLK);
        check("t5_busy_pre", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(data_a), 32'h0);
        check("t5_rst_flags", {28'h0, dv_a, pe_a, fe_a, busy_a}, 32'h0);
        drive(0, 1'b1, 3);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * BIT_CLK);
        frame(0, 8'h81, 1'b0, 2'b11, 3);
        check_queue(0, "t5_after_rst");

        // Randomised frames on both instances, including error cases
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            st = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
            frame(n % 2, d, pb, st, 3);
            check_queue(n % 2, "rand");
        end
`else
        // Fill a depth-4 FIFO with five frames and no reads
        for (int i = 1; i <= 5; i++) begin
            frame(0, 8'(i), 1'b0, 2'b11, 2);
            if (i == 4) begin
                check("t6_count4", 32'(cnt_a), 32'h4);
                check("t6_no_ovr", 32'(ovr_cnt), 32'h0);
            end
        end
        check("t6_count_full", 32'(cnt_a), 32'h4);
        check("t6_ovr", 32'(ovr_cnt), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            check("t6_dv", 32'(dv_a), 32'h1);
            check("t6_head", {22'h0, fe_a, pe_a, data_a}, 32'(i));
            pop_a();
        end
        check("t6_empty_dv", 32'(dv_a), 32'h0);
        check("t6_empty_data", 32'(data_a), 32'h0);
        check("t6_empty_count", 32'(cnt_a), 32'h0);
        pop_a();
        check("t6_pop_empty", 32'(cnt_a), 32'h0);

        // Randomised frames through the FIFO, one at a time
        for (int n = 0; n < 6; n++) begin
            d  = 8'($urandom);
            st = {1'b1, 1'($urandom_range(0, 3) != 0)};
            frame(0, d, 1'b0, st, 2);
            check("rand_dv", 32'(dv_a), 32'h1);
            check("rand_head", {22'h0, fe_a, pe_a, data_a}, 32'(model(d, 0, 1'b0, 1, st)));
            pop_a();
            check("rand_count", 32'(cnt_a), 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
